// File: rtl/ser_pkg.sv
// Shared types and constants for the bit serializer.
// Frame length grows by one when BIT_SERIALIZER_PARITY_EN appends a parity bit.
package ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam logic SER_IDLE_LEVEL = 1'b0;

    function automatic int frame_len(input int width, input bit parity_en);
        return parity_en ? width + 1 : width;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word in, one bit per clock out, gapless back-to-back.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             busy
);

`ifdef BIT_SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam int                 FRAME_LEN = frame_len(WIDTH, PARITY_EN);
    localparam int                 CNT_W     = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(FRAME_LEN - 1);

    ser_state_e           state_q;
    logic [FRAME_LEN-1:0] sr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ser_out_q;
    logic                 ser_valid_q;
    logic                 frame_start_q;

    logic [FRAME_LEN-1:0] frame_d;
    logic [FRAME_LEN-1:0] load_rest_d;
    logic [FRAME_LEN-1:0] sr_d;
    logic                 load_bit_d;
    logic                 next_bit_d;
    logic                 last_bit;
    logic                 accept;

    // Parity sits at the end of the frame in transmit order, whichever way we shift.
`ifdef BIT_SERIALIZER_PARITY_EN
    always_comb begin
        if (MSB_FIRST) frame_d = {data_in, ^data_in};
        else           frame_d = {^data_in, data_in};
    end
`else
    assign frame_d = data_in;
`endif

    // First bit goes straight to ser_out on accept; the register keeps only the remainder.
    always_comb begin
        if (MSB_FIRST) begin
            load_bit_d  = frame_d[FRAME_LEN-1];
            load_rest_d = frame_d << 1;
            next_bit_d  = sr_q[FRAME_LEN-1];
            sr_d        = sr_q << 1;
        end else begin
            load_bit_d  = frame_d[0];
            load_rest_d = frame_d >> 1;
            next_bit_d  = sr_q[0];
            sr_d        = sr_q >> 1;
        end
    end

    assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST_CNT);
    assign data_ready = (state_q == IDLE) || last_bit;
    assign accept     = data_valid && data_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            cnt_q         <= '0;
            ser_out_q     <= SER_IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (accept) begin
            state_q       <= SHIFT;
            sr_q          <= load_rest_d;
            cnt_q         <= '0;
            ser_out_q     <= load_bit_d;
            ser_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
        end else if (last_bit) begin
            state_q       <= IDLE;
            sr_q          <= '0;
            cnt_q         <= '0;
            ser_out_q     <= SER_IDLE_LEVEL;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            sr_q          <= sr_d;
            cnt_q         <= cnt_q + CNT_W'(1);
            ser_out_q     <= next_bit_d;
            frame_start_q <= 1'b0;
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q == SHIFT);

endmodule
